// File: rtl/fp_divider.sv
// Sequential IEEE-754 divider: restoring mantissa division (one quotient bit
// per clock), round-to-nearest-even, start/busy/done handshake.
module fp_divider #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic                    of,
  output logic                    dz,
  output logic [EXP_W+FRAC_W:0]   S
);

  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int MW   = FRAC_W + 1;
  localparam int QW   = FRAC_W + 4;
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(QW);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
  localparam logic signed [EW-1:0] ZERO_S = '0;
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;

  state_t state, state_next;

  logic [W-1:0]           a_r, b_r;
  logic                   sign;
  logic signed [EW-1:0]   e;
  logic [MW-1:0]          mb;
  logic [MW:0]            rem;
  logic [QW-1:0]          q;
  logic [CW-1:0]          cnt;
  logic                   sp_dz, sp_nan, sp_zero;
  logic [W-1:0]           res_s;
  logic                   res_of, res_dz;

  logic [EXP_W-1:0]       ea, eb;
  assign ea = a_r[W-2:FRAC_W];
  assign eb = b_r[W-2:FRAC_W];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = UNPACK;
      UNPACK:  state_next = DIVIDE;
      DIVIDE:  if (cnt == CW'(QW - 1)) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Remainder stays below 2*mb, so one trial subtraction per cycle suffices.
  logic            qbit;
  logic [MW:0]     diff, rem_sub, rem_next;
  always_comb begin
    diff     = rem - {1'b0, mb};
    qbit     = (rem >= {1'b0, mb});
    rem_sub  = qbit ? diff : rem;
    rem_next = {rem_sub[MW-1:0], 1'b0};
  end

  logic                  top, guard, sticky, inc, rem_nz;
  logic [MW-1:0]         mant0, mant;
  logic [MW:0]           sum;
  logic signed [EW-1:0]  e_adj, e_fin;
  logic [W-1:0]          rs;
  logic                  rof, rdz;
  always_comb begin
    rem_nz = |rem;
    top    = q[QW-1];
    mant0  = top ? q[QW-1:3] : q[QW-2:2];
    guard  = top ? q[2] : q[1];
    sticky = top ? ((|q[1:0]) | rem_nz) : (q[0] | rem_nz);
    e_adj  = top ? e : e - ONE_S;
    inc    = guard & (sticky | mant0[0]);
    sum    = {1'b0, mant0} + {{MW{1'b0}}, inc};
    mant   = sum[MW] ? sum[MW:1] : sum[MW-1:0];
    e_fin  = e_adj + {{(EW-1){1'b0}}, sum[MW]};
    rs     = '0;
    rof    = 1'b0;
    rdz    = 1'b0;
    if (sp_dz) begin
      rof = 1'b1;
      rdz = 1'b1;
    end else if (sp_nan) begin
      rof = 1'b1;
    end else if (sp_zero) begin
      rof = 1'b0;
    end else if ((e_fin >= EMAX_S) || (e_fin <= ZERO_S)) begin
      rof = 1'b1;
    end else begin
      rs = {sign, e_fin[EXP_W-1:0], mant[FRAC_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      of      <= 1'b0;
      dz      <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sign    <= 1'b0;
      e       <= '0;
      mb      <= '0;
      rem     <= '0;
      q       <= '0;
      cnt     <= '0;
      sp_dz   <= 1'b0;
      sp_nan  <= 1'b0;
      sp_zero <= 1'b0;
      res_s   <= '0;
      res_of  <= 1'b0;
      res_dz  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r  <= a;
            b_r  <= b;
            busy <= 1'b1;
          end
        end
        UNPACK: begin
          sign    <= a_r[W-1] ^ b_r[W-1];
          mb      <= {1'b1, b_r[FRAC_W-1:0]};
          rem     <= {1'b0, 1'b1, a_r[FRAC_W-1:0]};
          q       <= '0;
          cnt     <= '0;
          e       <= {2'b00, ea} - {2'b00, eb} + EW'(BIAS);
          sp_dz   <= (eb == '0);
          sp_nan  <= (ea == '1) || (eb == '1);
          sp_zero <= (ea == '0);
        end
        DIVIDE: begin
          rem <= rem_next;
          q   <= {q[QW-2:0], qbit};
          cnt <= cnt + CW'(1);
        end
        ROUND: begin
          res_s  <= rs;
          res_of <= rof;
          res_dz <= rdz;
        end
        DONE: begin
          S    <= res_s;
          of   <= res_of;
          dz   <= res_dz;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Sequential IEEE-754 floating-point divider; the inverse-operation companion to the team's FP multiplier. It shares that block's operand format, clk/reset naming and of/S result convention.
- Computes S = a / b with a restoring mantissa divider, one quotient bit per clock.
- Rounds to nearest-even.
- Sits beside the multiplier in the arithmetic datapath and is driven through a start/busy/done handshake.

Parameters:
- EXP_W, 8, exponent field width. BIAS = 2^(EXP_W-1)-1.
- FRAC_W, 23, fraction field width. Word width is 1+EXP_W+FRAC_W.
- Only the defaults (single precision) are verified.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- a  in  32  dividend, IEEE single.
- b  in  32  divisor, IEEE single.
- busy  out  1  high from the edge after start is accepted until done.
- done  out  1  one-cycle pulse; S/of/dz valid from this cycle onward.
- of  out  1  result out of range (overflow, underflow, divide-by-zero, Inf/NaN operand).
- dz  out  1  divide by zero.
- S  out  32  quotient, IEEE single.

Behaviour:
- Reset (synchronous, takes priority in every state): state=IDLE; S=0, of=0, dz=0, busy=0, done=0. Reset mid-operation aborts it with no done pulse.
- FSM states: IDLE -> UNPACK -> DIVIDE -> ROUND -> DONE -> IDLE.
- IDLE: on start=1, register a and b, set busy=1, go to UNPACK.
- start is ignored while busy=1. Operand changes after acceptance have no effect.
- UNPACK (1 cycle):
  - sign = a[31]^b[31].
  - ma = {1,a[22:0]}, mb = {1,b[22:0]}.
  - e = a[30:23] - b[30:23] + BIAS, computed as signed 10-bit.
  - Classify the special cases here.
- DIVIDE (FRAC_W+4 = 27 cycles): restoring division producing q[26:0] = floor(ma*2^26/mb), plus a remainder-nonzero flag.
- ROUND (1 cycle):
  - If q[26]=1: mant = q[26:3], guard = q[2], sticky = |q[1:0] | rem_nz.
  - Else: mant = q[25:2], guard = q[1], sticky = q[0] | rem_nz, and e = e-1.
  - RNE: increment mant if guard & (sticky | mant[0]).
  - A rounding carry out of mant shifts mant right and does e = e+1.
- DONE: register S/of/dz, pulse done=1 for one cycle, clear busy in the same cycle, return to IDLE.
- Outputs hold until the next DONE or reset.
- Fixed latency for all cases, including special cases: done=1 in the cycle after the 30th rising edge following the edge that sampled start. The next start is accepted in the cycle after done.
- Special cases (exponent field 0 means zero; denormals are treated as zero):
  - b zero: S=0, of=1, dz=1.
  - a or b exponent field = 255 (Inf/NaN): S=0, of=1, dz=0.
  - a zero, b finite nonzero: S=32'h0 (positive zero regardless of signs), of=0, dz=0.
  - Final e >= 255: S=0, of=1 (overflow flushes to zero).
  - Final e <= 0: S=0, of=1 (underflow flushes to zero).
  - Otherwise: S = {sign, e[7:0], mant[22:0]}, of=0, dz=0.
- Start and reset in the same cycle: reset wins; the start is dropped.

Test Plan:
- Exact quotient: a=0x42B60000 (91.0), b=0x40000000 (2.0), start one cycle -> busy high through the operation; done exactly 30 edges later; S=0x42360000 (45.5), of=0, dz=0.
- Rounding and sign:
  - a=0x3F800000 (1.0), b=0x40400000 (3.0) -> S=0x3EAAAAAB (RNE rounds up).
  - a=0x40C00000 (6.0), b=0xBFC00000 (-1.5) -> S=0xC0800000 (-4.0).
  - a=b=0xC2360000 (-45.5) -> S=0x3F800000 (1.0).
- Zero handling:
  - a=0, b=0xC2360000 -> S=0, of=0, dz=0.
  - a=0xC2360000, b=0 -> S=0, of=1, dz=1.
  - a=0x7F800000 (Inf), b=0x3F800000 -> S=0, of=1, dz=0.
- Range:
  - a=0x7F514CCD, b=0x0F514CCD -> overflow: S=0, of=1.
  - a=0x0F514CCD, b=0x7F514CCD -> underflow: S=0, of=1.
  - Both with done at 30 edges.
- Handshake:
  - start pulsed again at cycles 5 and 20 of an operation, with different operands -> ignored; exactly one done; result matches the first operands.
  - Back-to-back start in the cycle after done -> accepted.
- Reset mid-operation: assert reset for one cycle at cycle 10 of a divide -> busy=0, S=0, of=0, no done pulse. A following 91.0/2.0 -> S=0x42360000 after 30 edges.
